// File: rtl/dcache_mem_pkg.sv
// Shared definitions for the data-cache memory path: bridge state encoding,
// transfer direction flags and line-burst geometry.
package dcache_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_OUT  = 3'd3,
        ST_WR_PULL = 3'd4,
        ST_WR_CAP  = 3'd5,
        ST_WR_REQ  = 3'd6
    } bridge_state_e;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int BURST_WORDS = 4;
    localparam int HW_PER_WORD = 2;

endpackage

// File: rtl/dcache_mem_bridge.sv
// Converts 4-word cache line bursts into pairs of 16-bit req/ack accesses on
// the external halfword memory port, little-endian halfword order.
module dcache_mem_bridge
    import dcache_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 22,
    parameter int EXT_DATA_WIDTH = DATA_WIDTH / 2,
    parameter int BURST_WORDS    = dcache_mem_pkg::BURST_WORDS
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_Cache_Valid,
    input  logic                      i_Cache_Read_Write_n,
    input  logic [MEM_ADDR_WIDTH-1:0] i_Cache_Address,
    input  logic [DATA_WIDTH-1:0]     i_Cache_Data,
    output logic                      o_Cache_Valid,
    output logic                      o_Cache_Data_Read,
    output logic                      o_Cache_Last,
    output logic [DATA_WIDTH-1:0]     o_Cache_Data,
    output logic                      o_Ext_Req,
    output logic                      o_Ext_We,
    output logic [MEM_ADDR_WIDTH-1:0] o_Ext_Addr,
    output logic [EXT_DATA_WIDTH-1:0] o_Ext_Wdata,
    input  logic                      i_Ext_Ack,
    input  logic [EXT_DATA_WIDTH-1:0] i_Ext_Rdata
);

    localparam int WORD_IDX_W = $clog2(BURST_WORDS);
    localparam int HW_IDX_W   = $clog2(BURST_WORDS * HW_PER_WORD);

    bridge_state_e               state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0]   base_q, base_d;
    logic [HW_IDX_W-1:0]         hw_idx_q, hw_idx_d;
    logic [WORD_IDX_W-1:0]       word_idx_q, word_idx_d;
    logic [DATA_WIDTH-1:0]       rbuf_q, rbuf_d;
    logic [DATA_WIDTH-1:0]       wbuf_q, wbuf_d;

    logic                        last_word;
    logic                        hw_odd;
    logic [MEM_ADDR_WIDTH-1:0]   ext_addr;

    assign last_word = (word_idx_q == WORD_IDX_W'(BURST_WORDS - 1));
    assign hw_odd    = hw_idx_q[0];
    assign ext_addr  = base_q + MEM_ADDR_WIDTH'(hw_idx_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d           = state_q;
        base_d            = base_q;
        hw_idx_d          = hw_idx_q;
        word_idx_d        = word_idx_q;
        rbuf_d            = rbuf_q;
        wbuf_d            = wbuf_q;
        o_Cache_Valid     = 1'b0;
        o_Cache_Data_Read = 1'b0;
        o_Cache_Last      = 1'b0;
        o_Cache_Data      = '0;
        o_Ext_Req         = 1'b0;
        o_Ext_We          = 1'b0;
        o_Ext_Addr        = '0;
        o_Ext_Wdata       = '0;

        unique case (state_q)
            ST_IDLE: begin
                // The direction flag may still be stale here; it is sampled in SETTLE.
                if (i_Cache_Valid) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                base_d     = i_Cache_Address;
                hw_idx_d   = '0;
                word_idx_d = '0;
                state_d    = (i_Cache_Read_Write_n == READ) ? ST_RD_REQ : ST_WR_PULL;
            end
            ST_RD_REQ: begin
                o_Ext_Req  = 1'b1;
                o_Ext_Addr = ext_addr;
                if (i_Ext_Ack) begin
                    if (hw_odd) rbuf_d[DATA_WIDTH-1:EXT_DATA_WIDTH] = i_Ext_Rdata;
                    else        rbuf_d[EXT_DATA_WIDTH-1:0]          = i_Ext_Rdata;
                    hw_idx_d = hw_idx_q + 1'b1;
                    if (hw_odd) state_d = ST_RD_OUT;
                end
            end
            ST_RD_OUT: begin
                o_Cache_Valid = 1'b1;
                o_Cache_Data  = rbuf_q;
                o_Cache_Last  = last_word;
                word_idx_d    = word_idx_q + 1'b1;
                state_d       = last_word ? ST_IDLE : ST_RD_REQ;
            end
            ST_WR_PULL: begin
                o_Cache_Data_Read = 1'b1;
                o_Cache_Last      = last_word;
                state_d           = ST_WR_CAP;
            end
            ST_WR_CAP: begin
                // The cache loads the next word on the edge after the pulse.
                wbuf_d  = i_Cache_Data;
                state_d = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                o_Ext_Req   = 1'b1;
                o_Ext_We    = 1'b1;
                o_Ext_Addr  = ext_addr;
                o_Ext_Wdata = hw_odd ? wbuf_q[DATA_WIDTH-1:EXT_DATA_WIDTH]
                                     : wbuf_q[EXT_DATA_WIDTH-1:0];
                if (i_Ext_Ack) begin
                    hw_idx_d = hw_idx_q + 1'b1;
                    if (hw_odd) begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = last_word ? ST_IDLE : ST_WR_PULL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            hw_idx_q   <= '0;
            word_idx_q <= '0;
            rbuf_q     <= '0;
            wbuf_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            hw_idx_q   <= hw_idx_d;
            word_idx_q <= word_idx_d;
            rbuf_q     <= rbuf_d;
            wbuf_q     <= wbuf_d;
        end
    end

endmodule
